riscv_memory_arbiter: RTL and testbench
=======================================

// Module: riscv_memory_arbiter
// PURPOSE
// Shares the single external memory port between the instruction cache (read-only) and the data cache (read/write).
// Sits in the bus between both cache miss ports and the memory. It replaces the combinational mux with a sequenced controller:
// - one transaction in flight at a time;
// - responses are tagged by owner;
// - the instruction fetch is protected from starvation;
// - a response timeout unblocks the core.
// PARAMETERS
// STARVE_LIMIT  4    max consecutive data grants while an instruction request is pending (1..255)
// TIMEOUT       255  cycles to wait for a memory ready before aborting (1..255)
// PORTS
// clock               in   1   system clock, rising edge
// reset               in   1   asynchronous, active-low reset (0 = reset asserted)
// instr_read          in   1   icache miss read request, held until instr_ready
// instr_address       in   32  icache read address, stable while instr_read=1
// instr_data          out  32  read data to icache, valid when instr_ready=1
// instr_ready         out  1   1-cycle completion pulse to icache
// data_read           in   1   dcache read request, held until data_ready
// data_write          in   1   dcache write request, held until data_ready
// data_address        in   32  dcache address, stable while request high
// data_wdata          in   32  dcache write data, stable while data_write=1
// data_rdata          out  32  read data to dcache, valid when data_ready=1
// data_ready          out  1   1-cycle completion pulse to dcache
// memory_address      out  32  address to memory (registered)
// memory_read         out  1   1-cycle read strobe to memory (registered)
// memory_write        out  1   1-cycle write strobe to memory (registered)
// memory_out          out  32  write data to memory (registered)
// memory_in           in   32  read data from memory, valid with memory_read_ready
// memory_read_ready   in   1   read completed
// memory_write_ready  in   1   write completed
// bus_error           out  1   sticky: a transaction timed out; cleared only by reset
// BEHAVIOUR
// Reset values (async, reset=0):
// - All outputs 0; state IDLE; streak counter 0; timeout counter 0.
// States:
// - IDLE:  nothing in flight.
// - ISSUE: strobe cycle.
// - WAIT_I / WAIT_DR / WAIT_DW: waiting for the memory response.
// IDLE arbitration, evaluated at each rising edge:
// - The data cache wins by default.
// - The instruction cache wins if data requests nothing, or if instr_read=1 and streak>=STARVE_LIMIT.
// - If data_read and data_write are both 1, the write is issued; the read is treated as dropped.
// On a grant, latch the owner, memory_address and memory_out, and go to ISSUE.
// - In ISSUE, memory_read or memory_write is high for exactly one cycle; then go to WAIT_x.
// Streak counter (saturating, 8 bit):
// - Increments on a data grant made while instr_read=1.
// - Cleared on an instruction grant, or whenever instr_read=0 in IDLE.
// WAIT_I / WAIT_DR completion:
// - On memory_read_ready=1, pulse the owner's ready in the same cycle, combinationally.
// - The owner's data output equals memory_in in that cycle; next state is IDLE.
// WAIT_DW completion:
// - On memory_write_ready=1, pulse data_ready in the same cycle; next state is IDLE.
// Latency:
// - Minimum request-to-ready is 3 cycles: grant edge, ISSUE cycle, response one cycle after the strobe.
// - The next grant can be made on the edge that ends the ready cycle.
// Ready and data outputs:
// - A ready is never asserted outside the matching WAIT state. memory_*_ready seen in IDLE or ISSUE is ignored.
// - A read ready is ignored in WAIT_DW, and a write ready is ignored in WAIT_I/DR.
// - instr_data and data_rdata are 0 when their ready is 0.
// Timeout:
// - The timeout counter clears on entry to WAIT_x and increments each WAIT cycle.
// - When it reaches TIMEOUT: pulse the owner's ready with data 0, set bus_error, go to IDLE.
// - A late response arriving afterwards is ignored.
// Requests:
// - A requester that is still high on the cycle after its ready is a new request.
// - A request dropped before ready (illegal) does not cancel the transaction; the ready still pulses.
// Reset mid-transaction: the in-flight transaction is abandoned immediately, and the memory response after release is ignored.
// TESTING
// - Reset check: reset=0 with requests active -> all outputs 0. Release reset, instr_read=1 @0x100 -> memory_read=1 exactly 1 cycle with memory_address=0x100; memory_in=0xDEADBEEF -> instr_ready=1, instr_data=0xDEADBEEF for 1 cycle.
// - Write: data_write=1 @0x2000, wdata=0x12345678 -> memory_write=1, memory_out=0x12345678; memory_write_ready -> data_ready=1 for 1 cycle, instr_ready stays 0.
// - Contention: instr_read and data_read held permanently -> grants in order D,D,D,D,I,D,D,D,D,I (STARVE_LIMIT=4).
// - Tagging: memory_read_ready pulsed while in IDLE or in WAIT_DW -> no ready pulse on either requester.
// - Timeout: TIMEOUT=8, never answer -> 8 WAIT cycles, then ready pulse with data 0 and bus_error=1 sticky; a late memory_read_ready is ignored.
// - Abort: drive reset=0 while in WAIT_DR -> outputs 0 asynchronously; the response arriving after reset release produces no data_ready.

Source files
------------

// File: rtl/riscv_memory_arbiter.sv
// Sequenced arbiter sharing one external memory port between the icache (read-only)
// and the dcache (read/write): one transaction in flight, owner-tagged responses, timeout.
module riscv_memory_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_read,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_data,
  output logic        instr_ready,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_ready,
  output logic [31:0] memory_address,
  output logic        memory_read,
  output logic        memory_write,
  output logic [31:0] memory_out,
  input  logic [31:0] memory_in,
  input  logic        memory_read_ready,
  input  logic        memory_write_ready,
  output logic        bus_error
);

  localparam logic [7:0] STARVE_MAX  = 8'(STARVE_LIMIT);
  localparam logic [7:0] TIMEOUT_MAX = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_I, WAIT_DR, WAIT_DW} state_t;
  typedef enum logic [1:0] {OWN_I, OWN_DR, OWN_DW} owner_t;

  state_t     state, state_nxt;
  owner_t     owner;
  logic [7:0] streak;
  logic [7:0] wait_count;
  logic       grant_i, grant_dr, grant_dw;
  logic       timeout_hit;
  logic       data_req;
  logic       instr_wins;
  logic       in_wait;

  assign data_req   = data_read | data_write;
  assign instr_wins = instr_read & (~data_req | (streak >= STARVE_MAX));
  assign in_wait    = (state == WAIT_I) | (state == WAIT_DR) | (state == WAIT_DW);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    grant_i     = 1'b0;
    grant_dr    = 1'b0;
    grant_dw    = 1'b0;
    timeout_hit = 1'b0;
    instr_ready = 1'b0;
    instr_data  = '0;
    data_ready  = 1'b0;
    data_rdata  = '0;
    case (state)
      IDLE: begin
        // a simultaneous read+write from the dcache issues only the write
        if (instr_wins) begin
          grant_i   = 1'b1;
          state_nxt = ISSUE;
        end else if (data_write) begin
          grant_dw  = 1'b1;
          state_nxt = ISSUE;
        end else if (data_read) begin
          grant_dr  = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        case (owner)
          OWN_I:   state_nxt = WAIT_I;
          OWN_DR:  state_nxt = WAIT_DR;
          default: state_nxt = WAIT_DW;
        endcase
      end
      WAIT_I: begin
        if (memory_read_ready) begin
          instr_ready = 1'b1;
          instr_data  = memory_in;
          state_nxt   = IDLE;
        end else if (wait_count >= TIMEOUT_MAX) begin
          instr_ready = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DR: begin
        if (memory_read_ready) begin
          data_ready = 1'b1;
          data_rdata = memory_in;
          state_nxt  = IDLE;
        end else if (wait_count >= TIMEOUT_MAX) begin
          data_ready  = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      WAIT_DW: begin
        if (memory_write_ready) begin
          data_ready = 1'b1;
          state_nxt  = IDLE;
        end else if (wait_count >= TIMEOUT_MAX) begin
          data_ready  = 1'b1;
          timeout_hit = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      owner          <= OWN_I;
      streak         <= '0;
      wait_count     <= '0;
      bus_error      <= 1'b0;
      memory_address <= '0;
      memory_read    <= 1'b0;
      memory_write   <= 1'b0;
      memory_out     <= '0;
    end else begin
      memory_read  <= grant_i | grant_dr;
      memory_write <= grant_dw;
      if (grant_i | grant_dr | grant_dw) begin
        memory_address <= grant_i ? instr_address : data_address;
        memory_out     <= grant_dw ? data_wdata : 32'h0;
        owner          <= grant_i ? OWN_I : (grant_dw ? OWN_DW : OWN_DR);
      end
      // streak only counts data grants that actually made an instruction fetch wait
      if (state == IDLE) begin
        if (!instr_read || grant_i)
          streak <= '0;
        else if ((grant_dr | grant_dw) && (streak != 8'hFF))
          streak <= streak + 8'd1;
      end
      if (state == ISSUE)
        wait_count <= '0;
      else if (in_wait && (wait_count != 8'hFF))
        wait_count <= wait_count + 8'd1;
      if (timeout_hit)
        bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_memory_arbiter.sv
// Directed and randomized bench for riscv_memory_arbiter; the bench plays the memory
// and predicts grant order, latency and returned data from the arbitration rules.
module tb_riscv_memory_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        instr_read = 1'b0;
  logic [31:0] instr_address = '0;
  logic [31:0] instr_data;
  logic        instr_ready;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [31:0] data_address = '0;
  logic [31:0] data_wdata = '0;
  logic [31:0] data_rdata;
  logic        data_ready;
  logic [31:0] memory_address;
  logic        memory_read;
  logic        memory_write;
  logic [31:0] memory_out;
  logic [31:0] memory_in = '0;
  logic        memory_read_ready = 1'b0;
  logic        memory_write_ready = 1'b0;
  logic        bus_error;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] mem_model [logic [31:0]];

  riscv_memory_arbiter #(.STARVE_LIMIT(STARVE), .TIMEOUT(TMO)) dut (
    .clock              (clock),
    .reset              (reset),
    .instr_read         (instr_read),
    .instr_address      (instr_address),
    .instr_data         (instr_data),
    .instr_ready        (instr_ready),
    .data_read          (data_read),
    .data_write         (data_write),
    .data_address       (data_address),
    .data_wdata         (data_wdata),
    .data_rdata         (data_rdata),
    .data_ready         (data_ready),
    .memory_address     (memory_address),
    .memory_read        (memory_read),
    .memory_write       (memory_write),
    .memory_out         (memory_out),
    .memory_in          (memory_in),
    .memory_read_ready  (memory_read_ready),
    .memory_write_ready (memory_write_ready),
    .bus_error          (bus_error)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    instr_read         = 1'b0;
    data_read          = 1'b0;
    data_write         = 1'b0;
    memory_read_ready  = 1'b0;
    memory_write_ready = 1'b0;
  endtask

  task automatic wait_strobe(input int limit, output int waited, output bit found);
    found  = 1'b0;
    waited = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clock);
      if (memory_read || memory_write) begin
        found  = 1'b1;
        waited = i;
        break;
      end
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rdy"}, 32'({instr_ready, data_ready}), 32'd0);
    check({tag, "_dat"}, instr_data | data_rdata, 32'd0);
  endtask

  // who: 0 = instruction read, 1 = data read, 2 = data write
  task automatic do_txn(input int who, input logic [31:0] addr, input logic [31:0] wd,
                        input int delay, input bit noise, input string tag);
    int          waited;
    bit          found;
    logic [31:0] exp;
    next_cycle();
    case (who)
      0:       begin instr_read = 1'b1; instr_address = addr; end
      1:       begin data_read = 1'b1; data_address = addr; end
      default: begin data_write = 1'b1; data_address = addr; data_wdata = wd; end
    endcase
    wait_strobe(8, waited, found);
    check({tag, "_strobe"}, 32'(found), 32'd1);
    if (!found) begin
      idle_inputs();
      return;
    end
    check({tag, "_lat"}, waited, 32'd1);
    check({tag, "_rd"}, 32'(memory_read), 32'(who != 2));
    check({tag, "_wr"}, 32'(memory_write), 32'(who == 2));
    check({tag, "_addr"}, memory_address, addr);
    if (who == 2) check({tag, "_wdata"}, memory_out, wd);
    for (int d = 0; d < delay; d++) begin
      next_cycle();
      if (noise) begin
        if (who == 2) memory_read_ready = 1'b1;
        else          memory_write_ready = 1'b1;
      end
      sample();
      check_quiet({tag, "_wait"});
      memory_read_ready  = 1'b0;
      memory_write_ready = 1'b0;
    end
    next_cycle();
    if (who == 2) memory_write_ready = 1'b1;
    else begin
      memory_read_ready = 1'b1;
      memory_in         = mem_word(addr);
    end
    sample();
    exp = (who == 2) ? 32'd0 : mem_word(addr);
    check({tag, "_strobe1"}, 32'({memory_read, memory_write}), 32'd0);
    check({tag, "_irdy"}, 32'(instr_ready), 32'(who == 0));
    check({tag, "_drdy"}, 32'(data_ready), 32'(who != 0));
    check({tag, "_idat"}, instr_data, (who == 0) ? exp : 32'd0);
    check({tag, "_ddat"}, data_rdata, (who == 1) ? exp : 32'd0);
    if (who == 2) mem_model[addr] = wd;
    next_cycle();
    idle_inputs();
    memory_in = 32'hFFFFFFFF;
    sample();
    check_quiet({tag, "_after"});
  endtask

  initial begin
    int          waited;
    bit          found;
    int          n;
    bit          got;
    bit          exp_i;
    int          dly;
    logic [31:0] a;

    // reset held with every request and response active
    instr_read = 1'b1; data_read = 1'b1; data_write = 1'b1;
    instr_address = 32'h100; data_address = 32'h200; data_wdata = 32'hCAFEF00D;
    memory_read_ready = 1'b1; memory_write_ready = 1'b1; memory_in = 32'hDEADBEEF;
    #22;
    check("rst_irdy", 32'(instr_ready), 32'd0);
    check("rst_idat", instr_data, 32'd0);
    check("rst_drdy", 32'(data_ready), 32'd0);
    check("rst_ddat", data_rdata, 32'd0);
    check("rst_maddr", memory_address, 32'd0);
    check("rst_mstb", 32'({memory_read, memory_write}), 32'd0);
    check("rst_mout", memory_out, 32'd0);
    check("rst_berr", 32'(bus_error), 32'd0);
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;

    mem_model[32'h100] = 32'hDEADBEEF;
    do_txn(0, 32'h100, 32'h0, 0, 1'b0, "ifetch");
    do_txn(2, 32'h2000, 32'h12345678, 1, 1'b1, "write");
    do_txn(1, 32'h2000, 32'h0, 2, 1'b1, "rdback");

    for (int k = 0; k < 12; k++) begin
      do_txn($urandom_range(0, 2), 32'h1000 + 32'($urandom_range(0, 7)) * 32'd4,
             $urandom, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
             $sformatf("rnd%0d", k));
    end

    // responses seen in IDLE must not reach either requester
    next_cycle();
    memory_read_ready = 1'b1; memory_write_ready = 1'b1; memory_in = 32'h0BADF00D;
    sample();
    check_quiet("idle_resp");
    next_cycle();
    idle_inputs();

    // both caches hold read requests permanently
    next_cycle();
    instr_read = 1'b1; instr_address = 32'h4000;
    data_read = 1'b1;  data_address = 32'h8000;
    for (int k = 0; k < 10; k++) begin
      wait_strobe(8, waited, found);
      check($sformatf("cont%0d_strobe", k), 32'(found), 32'd1);
      if (!found) break;
      exp_i = ((k % (STARVE + 1)) == STARVE);
      check($sformatf("cont%0d_owner", k), memory_address, exp_i ? 32'h4000 : 32'h8000);
      a   = memory_address;
      dly = $urandom_range(0, 3);
      for (int d = 0; d < dly; d++) begin
        next_cycle();
        sample();
        check_quiet($sformatf("cont%0d_wait%0d", k, d));
      end
      next_cycle();
      memory_read_ready = 1'b1;
      memory_in         = mem_word(a);
      sample();
      check($sformatf("cont%0d_irdy", k), 32'(instr_ready), 32'(exp_i));
      check($sformatf("cont%0d_drdy", k), 32'(data_ready), 32'(!exp_i));
      check($sformatf("cont%0d_dat", k), exp_i ? instr_data : data_rdata, mem_word(a));
      next_cycle();
      memory_read_ready = 1'b0;
    end
    idle_inputs();

    // unanswered read times out
    next_cycle();
    data_read = 1'b1; data_address = 32'h3000;
    wait_strobe(8, waited, found);
    check("tmo_strobe", 32'(found), 32'd1);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      sample();
      if (data_ready) begin
        got = 1'b1;
        break;
      end
      n++;
    end
    check("tmo_pulse", 32'(got), 32'd1);
    check("tmo_cycles", n, TMO);
    check("tmo_data", data_rdata, 32'd0);
    check("tmo_irdy", 32'(instr_ready), 32'd0);
    next_cycle();
    data_read = 1'b0;
    memory_read_ready = 1'b1; memory_in = 32'h77777777;
    sample();
    check_quiet("tmo_late");
    check("tmo_berr", 32'(bus_error), 32'd1);
    next_cycle();
    memory_read_ready = 1'b0;
    do_txn(0, 32'h140, 32'h0, 1, 1'b0, "post_tmo");
    check("berr_sticky", 32'(bus_error), 32'd1);

    // reset asserted while a data read is waiting
    next_cycle();
    data_read = 1'b1; data_address = 32'h5000;
    wait_strobe(8, waited, found);
    check("abort_strobe", 32'(found), 32'd1);
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    check("abort_maddr", memory_address, 32'd0);
    check("abort_mstb", 32'({memory_read, memory_write}), 32'd0);
    check("abort_berr", 32'(bus_error), 32'd0);
    check_quiet("abort_out");
    data_read = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    next_cycle();
    memory_read_ready = 1'b1; memory_in = 32'h13579BDF;
    sample();
    check_quiet("abort_late");
    next_cycle();
    idle_inputs();
    do_txn(1, 32'h6000, 32'h0, 0, 1'b0, "recover");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
